// File: rtl/tensor_burst_sequencer_if.sv
// Command, write-beat and read-beat streams between the instruction decoder side
// and the tensor burst sequencer.
interface tensor_burst_sequencer_if #(
  parameter int DATA_WIDTH = 8,
  parameter int LANES      = 4
);
  logic                        cmd_valid_in;
  logic [1:0]                  cmd_op_in;
  logic                        cmd_ready_out;
  logic [LANES*DATA_WIDTH-1:0] wr_data_in;
  logic                        wr_valid_in;
  logic                        wr_ready_out;
  logic [LANES*DATA_WIDTH-1:0] rd_data_out;
  logic                        rd_valid_out;
  logic                        rd_ready_in;
  logic                        rd_last_out;

  modport master (
    output cmd_valid_in, cmd_op_in, wr_data_in, wr_valid_in, rd_ready_in,
    input  cmd_ready_out, wr_ready_out, rd_data_out, rd_valid_out, rd_last_out
  );

  modport slave (
    input  cmd_valid_in, cmd_op_in, wr_data_in, wr_valid_in, rd_ready_in,
    output cmd_ready_out, wr_ready_out, rd_data_out, rd_valid_out, rd_last_out
  );
endinterface

// File: rtl/tensor_burst_sequencer.sv
// Burst read/write sequencing of a full tensor operand set through the register
// file, plus the start / write-back interlock for the tensor core.
module tensor_burst_sequencer #(
  parameter int DATA_WIDTH      = 8,
  parameter int MATRIX_DIM      = 3,
  parameter int NUM_MATRICES    = 2,
  parameter int LANES           = 4,
  parameter int COMPUTE_LATENCY = 6,
  localparam int TOTAL = NUM_MATRICES * MATRIX_DIM * MATRIX_DIM,
  localparam int BEATS = (TOTAL + LANES - 1) / LANES,
  localparam int AW    = (TOTAL > 1) ? $clog2(TOTAL) : 1,
  localparam int WW    = LANES * DATA_WIDTH
) (
  input  logic                   clock_in,
  input  logic                   reset_in,
  input  logic                   abort_in,
  tensor_burst_sequencer_if.slave bus,
  output logic                   rf_write_enable_out,
  output logic [AW-1:0]          rf_write_base_address_out,
  output logic [LANES-1:0]       rf_write_lane_mask_out,
  output logic [WW-1:0]          rf_write_data_out,
  output logic [AW-1:0]          rf_read_base_address_out,
  input  logic [WW-1:0]          rf_read_data_in,
  output logic                   tc_start_out,
  output logic                   tc_writeback_out,
  output logic                   busy_out
);
  localparam int BCW = $clog2(BEATS + 1);
  localparam int TW  = $clog2(COMPUTE_LATENCY + 1);
  localparam logic [BCW-1:0] BEATS_C   = BCW'(BEATS);
  localparam logic [BCW-1:0] LAST_BEAT = BCW'(BEATS - 1);
  localparam logic [TW-1:0]  TIMER_END = TW'(COMPUTE_LATENCY);
  localparam logic [TW-1:0]  TIMER_WB  = TW'(COMPUTE_LATENCY - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WRITE   = 2'd1,
    ST_READ    = 2'd2,
    ST_COMPUTE = 2'd3
  } state_t;

  state_t           state_r;
  state_t           state_nxt_s;
  logic [BCW-1:0]   beat_r;
  logic [TW-1:0]    timer_r;
  logic [WW-1:0]    rd_data_r;
  logic             rd_valid_r;
  logic             rd_last_r;
  logic             tc_start_r;
  logic             tc_writeback_r;
  logic             abort_s;
  logic             cmd_fire_s;
  logic             wr_fire_s;
  logic             rd_load_s;
  logic             rd_take_s;
  logic             last_beat_s;
  logic             wb_due_s;
  logic [AW-1:0]    base_addr_s;
  logic [LANES-1:0] lane_mask_s;

  // Lanes whose element index still lies inside the operand set.
  function automatic logic [LANES-1:0] beat_mask(input logic [BCW-1:0] beat);
    logic [LANES-1:0] m;
    m = {LANES{1'b0}};
    for (int i = 0; i < LANES; i++) begin
      m[i] = ((int'(beat) * LANES + i) < TOTAL);
    end
    return m;
  endfunction

  function automatic logic [WW-1:0] mask_data(input logic [WW-1:0] d, input logic [LANES-1:0] m);
    logic [WW-1:0] r;
    r = {WW{1'b0}};
    for (int i = 0; i < LANES; i++) begin
      r[i*DATA_WIDTH +: DATA_WIDTH] = m[i] ? d[i*DATA_WIDTH +: DATA_WIDTH] : {DATA_WIDTH{1'b0}};
    end
    return r;
  endfunction

  // An abort in IDLE is ignored so a command arriving with it is still taken.
  assign abort_s     = abort_in && (state_r != ST_IDLE);
  assign cmd_fire_s  = bus.cmd_valid_in && (state_r == ST_IDLE);
  assign wr_fire_s   = (state_r == ST_WRITE) && bus.wr_valid_in && !abort_in;
  assign rd_take_s   = rd_valid_r && bus.rd_ready_in;
  assign rd_load_s   = (state_r == ST_READ) && !abort_in && (beat_r < BEATS_C) &&
                       (!rd_valid_r || bus.rd_ready_in);
  assign last_beat_s = (beat_r == LAST_BEAT);
  assign wb_due_s    = (state_r == ST_COMPUTE) && (timer_r == TIMER_WB);
  assign base_addr_s = AW'(int'(beat_r) * LANES);
  assign lane_mask_s = beat_mask(beat_r);

  assign bus.cmd_ready_out = (state_r == ST_IDLE);
  assign bus.wr_ready_out  = (state_r == ST_WRITE);
  assign bus.rd_data_out   = rd_data_r;
  assign bus.rd_valid_out  = rd_valid_r;
  assign bus.rd_last_out   = rd_last_r;
  assign tc_start_out      = tc_start_r;
  assign tc_writeback_out  = tc_writeback_r;
  assign busy_out          = (state_r != ST_IDLE);

  // State register.
  always_ff @(posedge clock_in) begin
    if (reset_in) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state decode.
  always_comb begin
    state_nxt_s = state_r;
    if (abort_s) begin
      state_nxt_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (cmd_fire_s) begin
            case (bus.cmd_op_in)
              2'b00:   state_nxt_s = ST_READ;
              2'b01:   state_nxt_s = ST_WRITE;
              2'b10:   state_nxt_s = ST_COMPUTE;
              default: state_nxt_s = ST_IDLE;
            endcase
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end
        ST_WRITE:   state_nxt_s = (wr_fire_s && last_beat_s) ? ST_IDLE : ST_WRITE;
        ST_READ:    state_nxt_s = (rd_take_s && rd_last_r) ? ST_IDLE : ST_READ;
        ST_COMPUTE: state_nxt_s = (timer_r == TIMER_END) ? ST_IDLE : ST_COMPUTE;
        default:    state_nxt_s = ST_IDLE;
      endcase
    end
  end

  // Register-file write strobe follows the accepted write beat in the same cycle.
  always_comb begin
    rf_write_enable_out       = 1'b0;
    rf_write_base_address_out = {AW{1'b0}};
    rf_write_lane_mask_out    = {LANES{1'b0}};
    rf_write_data_out         = {WW{1'b0}};
    rf_read_base_address_out  = base_addr_s;
    if (wr_fire_s) begin
      rf_write_enable_out       = 1'b1;
      rf_write_base_address_out = base_addr_s;
      rf_write_lane_mask_out    = lane_mask_s;
      rf_write_data_out         = mask_data(bus.wr_data_in, lane_mask_s);
    end else begin
      rf_write_enable_out       = 1'b0;
    end
  end

  // Beat counter, compute timer and registered stream/strobe outputs.
  always_ff @(posedge clock_in) begin
    if (reset_in || abort_s) begin
      beat_r         <= {BCW{1'b0}};
      timer_r        <= {TW{1'b0}};
      rd_data_r      <= {WW{1'b0}};
      rd_valid_r     <= 1'b0;
      rd_last_r      <= 1'b0;
      tc_start_r     <= 1'b0;
      tc_writeback_r <= 1'b0;
    end else begin
      tc_start_r     <= cmd_fire_s && (bus.cmd_op_in == 2'b10);
      tc_writeback_r <= wb_due_s;
      case (state_r)
        ST_WRITE: begin
          if (wr_fire_s) begin
            beat_r <= last_beat_s ? {BCW{1'b0}} : beat_r + BCW'(1);
          end else begin
            beat_r <= beat_r;
          end
        end
        ST_READ: begin
          if (rd_load_s) begin
            rd_data_r  <= mask_data(rf_read_data_in, lane_mask_s);
            rd_valid_r <= 1'b1;
            rd_last_r  <= last_beat_s;
            beat_r     <= beat_r + BCW'(1);
          end else if (rd_take_s) begin
            rd_valid_r <= 1'b0;
            rd_last_r  <= 1'b0;
            beat_r     <= rd_last_r ? {BCW{1'b0}} : beat_r;
          end else begin
            rd_valid_r <= rd_valid_r;
          end
        end
        ST_COMPUTE: begin
          timer_r <= (timer_r == TIMER_END) ? {TW{1'b0}} : timer_r + TW'(1);
        end
        default: begin
          beat_r  <= {BCW{1'b0}};
          timer_r <= {TW{1'b0}};
        end
      endcase
    end
  end
endmodule

// File: tb/tb_tensor_burst_sequencer.sv
// Scoreboard bench: default instance for write/read/compute/abort, a wide-lane
// instance for mid-read reset and an unmasked rerun.
module tb_tensor_burst_sequencer;
  typedef struct {
    logic [4:0]  addr;
    logic [3:0]  mask;
    logic [31:0] data;
  } wr_item_t;

  typedef struct {
    logic [63:0] data;
    logic        last;
  } rd_item_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset1, reset2, abort1, abort2;
  logic        rf_we1, tc_start1, tc_wb1, busy1;
  logic [4:0]  rf_waddr1, rf_raddr1;
  logic [3:0]  rf_mask1;
  logic [31:0] rf_wdata1, rf_rdata1;
  logic        rf_we2, tc_start2, tc_wb2, busy2;
  logic [4:0]  rf_waddr2, rf_raddr2;
  logic [7:0]  rf_mask2;
  logic [63:0] rf_wdata2, rf_rdata2;

  tensor_burst_sequencer_if #(.DATA_WIDTH(8), .LANES(4)) bus1 ();
  tensor_burst_sequencer_if #(.DATA_WIDTH(8), .LANES(8)) bus2 ();

  tensor_burst_sequencer dut1 (
    .clock_in(clk), .reset_in(reset1), .abort_in(abort1), .bus(bus1.slave),
    .rf_write_enable_out(rf_we1), .rf_write_base_address_out(rf_waddr1),
    .rf_write_lane_mask_out(rf_mask1), .rf_write_data_out(rf_wdata1),
    .rf_read_base_address_out(rf_raddr1), .rf_read_data_in(rf_rdata1),
    .tc_start_out(tc_start1), .tc_writeback_out(tc_wb1), .busy_out(busy1)
  );

  tensor_burst_sequencer #(.MATRIX_DIM(4), .LANES(8)) dut2 (
    .clock_in(clk), .reset_in(reset2), .abort_in(abort2), .bus(bus2.slave),
    .rf_write_enable_out(rf_we2), .rf_write_base_address_out(rf_waddr2),
    .rf_write_lane_mask_out(rf_mask2), .rf_write_data_out(rf_wdata2),
    .rf_read_base_address_out(rf_raddr2), .rf_read_data_in(rf_rdata2),
    .tc_start_out(tc_start2), .tc_writeback_out(tc_wb2), .busy_out(busy2)
  );

  // Register-file model: mem[e] = e.
  always_comb begin
    rf_rdata1 = 32'd0;
    rf_rdata2 = 64'd0;
    for (int i = 0; i < 4; i++) rf_rdata1[i*8 +: 8] = 8'(int'(rf_raddr1) + i);
    for (int i = 0; i < 8; i++) rf_rdata2[i*8 +: 8] = 8'(int'(rf_raddr2) + i);
  end

  int n_total = 0;
  int n_bad   = 0;
  int hs1 = 0, hs2 = 0, ts_cnt = 0, wb_cnt = 0;
  wr_item_t wr_q[$];
  rd_item_t rd_q1[$];
  rd_item_t rd_q2[$];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] exp_rd(input int beat, input int lanes, input int total);
    logic [63:0] v;
    v = 64'd0;
    for (int i = 0; i < lanes; i++) begin
      if (beat * lanes + i < total) v[i*8 +: 8] = 8'(beat * lanes + i);
    end
    return v;
  endfunction

  task automatic send_cmd(input int sel, input logic [1:0] op);
    int waited;
    waited = 0;
    while (((sel == 1) ? !bus1.cmd_ready_out : !bus2.cmd_ready_out) && waited < 50) begin
      tick();
      waited++;
    end
    if (waited >= 50) check_eq("cmd_ready_timeout", 64'(waited), 64'd0);
    if (sel == 1) begin
      bus1.cmd_valid_in = 1'b1; bus1.cmd_op_in = op;
    end else begin
      bus2.cmd_valid_in = 1'b1; bus2.cmd_op_in = op;
    end
    tick();
    bus1.cmd_valid_in = 1'b0;
    bus2.cmd_valid_in = 1'b0;
  endtask

  task automatic wr_beat(input logic [4:0] addr, input logic [3:0] mask,
                         input logic [31:0] din, input logic [31:0] dexp);
    wr_item_t it;
    it.addr = addr; it.mask = mask; it.data = dexp;
    wr_q.push_back(it);
    bus1.wr_valid_in = 1'b1;
    bus1.wr_data_in  = din;
    tick();
    bus1.wr_valid_in = 1'b0;
  endtask

  // Scoreboard: compare every rf write and every presented read beat.
  always @(negedge clk) begin
    if (rf_we1) begin
      if (wr_q.size() == 0) begin
        check_eq("wr_extra_beat", 64'(wr_q.size()), 64'd1);
      end else begin
        check_eq("wr_addr", 64'(rf_waddr1), 64'(wr_q[0].addr));
        check_eq("wr_mask", 64'(rf_mask1), 64'(wr_q[0].mask));
        check_eq("wr_data", 64'(rf_wdata1), 64'(wr_q[0].data));
        void'(wr_q.pop_front());
      end
    end
    if (bus1.rd_valid_out) begin
      if (rd_q1.size() == 0) begin
        if (bus1.rd_ready_in) check_eq("rd1_extra_beat", 64'(rd_q1.size()), 64'd1);
      end else begin
        check_eq("rd1_data", 64'(bus1.rd_data_out), rd_q1[0].data);
        if (bus1.rd_ready_in) begin
          check_eq("rd1_last", 64'(bus1.rd_last_out), 64'(rd_q1[0].last));
          void'(rd_q1.pop_front());
          hs1++;
        end
      end
    end
    if (bus2.rd_valid_out && bus2.rd_ready_in) begin
      if (rd_q2.size() == 0) begin
        check_eq("rd2_extra_beat", 64'(rd_q2.size()), 64'd1);
      end else begin
        check_eq("rd2_data", bus2.rd_data_out, rd_q2[0].data);
        check_eq("rd2_last", 64'(bus2.rd_last_out), 64'(rd_q2[0].last));
        void'(rd_q2.pop_front());
        hs2++;
      end
    end
    if (tc_start1) ts_cnt++;
    if (tc_wb1) wb_cnt++;
  end

  logic [31:0] wr_tbl [5];
  logic [3:0]  mask_tbl [5];
  logic [31:0] wexp_tbl [5];

  initial begin
    int start, lat, ts0, wb0;
    logic ready_seen;
    rd_item_t ri;

    wr_tbl   = '{32'h04030201, 32'h08070605, 32'h0C0B0A09, 32'h100F0E0D, 32'h14131211};
    mask_tbl = '{4'hF, 4'hF, 4'hF, 4'hF, 4'h3};
    wexp_tbl = '{32'h04030201, 32'h08070605, 32'h0C0B0A09, 32'h100F0E0D, 32'h00001211};

    reset1 = 1'b1; reset2 = 1'b1; abort1 = 1'b0; abort2 = 1'b0;
    bus1.cmd_valid_in = 1'b0; bus1.cmd_op_in = 2'b00; bus1.wr_valid_in = 1'b0;
    bus1.wr_data_in = 32'd0; bus1.rd_ready_in = 1'b1;
    bus2.cmd_valid_in = 1'b0; bus2.cmd_op_in = 2'b00; bus2.wr_valid_in = 1'b0;
    bus2.wr_data_in = 64'd0; bus2.rd_ready_in = 1'b1;
    tick(); tick();
    check_eq("rst_cmd_ready", 64'(bus1.cmd_ready_out), 64'd1);
    check_eq("rst_busy", 64'(busy1), 64'd0);
    check_eq("rst_wr_ready", 64'(bus1.wr_ready_out), 64'd0);
    check_eq("rst_rd_valid", 64'(bus1.rd_valid_out), 64'd0);
    check_eq("rst_rd_data", 64'(bus1.rd_data_out), 64'd0);
    check_eq("rst_tc", 64'({tc_start1, tc_wb1, rf_we1}), 64'd0);
    reset1 = 1'b0; reset2 = 1'b0;

    // Burst write with one stall cycle.
    send_cmd(1, 2'b01);
    check_eq("wr_ready_in_write", 64'(bus1.wr_ready_out), 64'd1);
    for (int k = 0; k < 5; k++) begin
      if (k == 2) tick();
      wr_beat(5'(k * 4), mask_tbl[k], wr_tbl[k], wexp_tbl[k]);
    end
    check_eq("wr_done_idle", 64'({busy1, bus1.cmd_ready_out}), 64'b01);
    check_eq("wr_q_left", 64'(wr_q.size()), 64'd0);

    // Burst read with consumer always ready.
    for (int k = 0; k < 5; k++) begin
      ri.data = exp_rd(k, 4, 18); ri.last = (k == 4); rd_q1.push_back(ri);
    end
    check_eq("rd_beat0_model", rd_q1[0].data, 64'h03020100);
    check_eq("rd_beat4_model", rd_q1[4].data, 64'h00001110);
    bus1.rd_ready_in = 1'b1;
    send_cmd(1, 2'b00);
    check_eq("rd_lat_c0", 64'(bus1.rd_valid_out), 64'd0);
    tick();
    check_eq("rd_lat_c1", 64'(bus1.rd_valid_out), 64'd1);
    for (int i = 0; i < 20 && !(bus1.rd_valid_out && bus1.rd_last_out); i++) tick();
    tick();
    check_eq("rd_done_ready", 64'(bus1.cmd_ready_out), 64'd1);
    check_eq("rd_q_left", 64'(rd_q1.size()), 64'd0);

    // Burst read with back-pressure 1,0,0,1,...
    for (int k = 0; k < 5; k++) begin
      ri.data = exp_rd(k, 4, 18); ri.last = (k == 4); rd_q1.push_back(ri);
    end
    start = hs1;
    send_cmd(1, 2'b00);
    for (int i = 0; i < 60 && (hs1 - start) < 5; i++) begin
      bus1.rd_ready_in = (i % 3 == 0);
      tick();
    end
    bus1.rd_ready_in = 1'b1;
    check_eq("rd_bp_handshakes", 64'(hs1 - start), 64'd5);
    check_eq("rd_bp_idle", 64'(busy1), 64'd0);
    tick();
    check_eq("rd_bp_no_extra", 64'(hs1 - start), 64'd5);

    // Compute with a write command held meanwhile.
    send_cmd(1, 2'b10);
    check_eq("tc_start_pulse", 64'(tc_start1), 64'd1);
    bus1.cmd_valid_in = 1'b1; bus1.cmd_op_in = 2'b01;
    lat = 0; ready_seen = 1'b0;
    for (int j = 1; j <= 20; j++) begin
      tick();
      if (bus1.cmd_ready_out) ready_seen = 1'b1;
      if (tc_wb1) begin lat = j; break; end
    end
    check_eq("tc_wb_latency", 64'(lat), 64'd6);
    check_eq("tc_start_one_cycle", 64'(tc_start1), 64'd0);
    check_eq("cmd_held_not_ready", 64'(ready_seen), 64'd0);
    tick();
    check_eq("compute_done_busy", 64'(busy1), 64'd0);
    tick();
    check_eq("held_cmd_taken", 64'(bus1.wr_ready_out), 64'd1);
    bus1.cmd_valid_in = 1'b0;

    // Abort after two write beats, then restart.
    wr_beat(5'd0, 4'hF, 32'hA1A2A3A4, 32'hA1A2A3A4);
    wr_beat(5'd4, 4'hF, 32'hB1B2B3B4, 32'hB1B2B3B4);
    abort1 = 1'b1;
    tick();
    abort1 = 1'b0;
    check_eq("abort_wr_idle", 64'(busy1), 64'd0);
    bus1.wr_valid_in = 1'b1; bus1.wr_data_in = 32'hDEADBEEF;
    tick();
    bus1.wr_valid_in = 1'b0;
    send_cmd(1, 2'b01);
    wr_beat(5'd0, 4'hF, 32'h11223344, 32'h11223344);
    abort1 = 1'b1;
    tick();
    abort1 = 1'b0;
    check_eq("abort_wr_q_left", 64'(wr_q.size()), 64'd0);

    // Abort in COMPUTE at timer 3 suppresses write-back.
    ts0 = ts_cnt; wb0 = wb_cnt;
    send_cmd(1, 2'b10);
    tick(); tick(); tick();
    abort1 = 1'b1;
    tick();
    abort1 = 1'b0;
    check_eq("abort_tc_idle", 64'(busy1), 64'd0);
    repeat (10) tick();
    check_eq("abort_tc_no_wb", 64'(wb_cnt - wb0), 64'd0);
    check_eq("abort_tc_one_start", 64'(ts_cnt - ts0), 64'd1);

    // Wide instance: reset in the middle of a read.
    bus2.rd_ready_in = 1'b0;
    send_cmd(2, 2'b00);
    tick(); tick();
    check_eq("rd2_stalled_valid", 64'(bus2.rd_valid_out), 64'd1);
    reset2 = 1'b1;
    tick();
    reset2 = 1'b0;
    check_eq("rst2_ready_busy", 64'({bus2.cmd_ready_out, busy2}), 64'b10);
    check_eq("rst2_rd", 64'({bus2.rd_valid_out, bus2.rd_last_out, bus2.wr_ready_out}), 64'd0);
    check_eq("rst2_rd_data", bus2.rd_data_out, 64'd0);
    check_eq("rst2_tc_we", 64'({tc_start2, tc_wb2, rf_we2}), 64'd0);
    check_eq("rst2_addr", 64'({rf_raddr2, rf_waddr2, rf_mask2}), 64'd0);
    check_eq("rst2_wdata", rf_wdata2, 64'd0);

    for (int k = 0; k < 4; k++) begin
      ri.data = exp_rd(k, 8, 32); ri.last = (k == 3); rd_q2.push_back(ri);
    end
    bus2.rd_ready_in = 1'b1;
    start = hs2;
    send_cmd(2, 2'b00);
    for (int i = 0; i < 30 && (hs2 - start) < 4; i++) tick();
    check_eq("rd2_handshakes", 64'(hs2 - start), 64'd4);
    check_eq("rd2_idle", 64'(busy2), 64'd0);
    check_eq("rd2_q_left", 64'(rd_q2.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
